// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer.
// The sequencer pushes the operands one bit per clock, LSB first, through a
// single fulladd cell. A start/done/ack handshake frames each addition, and
// the result is held on sum/cout until the next accepted start.

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ack,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter sized to hold 0..WIDTH; RUN ends on the edge where it reads WIDTH-1.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_s_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] sum_shift_d;

  // The one shared single-bit adder; it always sees the current LSBs and carry.
  fulladd u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // New sum bit enters at the MSB; a 1-bit build simply takes the bit.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_shift_d = fa_s_s;
  end else begin : g_sum_wn
    assign sum_shift_d = {fa_s_s, sum_q[WIDTH-1:1]};
  end

  // Sequencer: state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= {WIDTH{1'b0}};
      b_sr_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // start and ack are deliberately not looked at while running
          sum_q   <= sum_shift_d;
          carry_q <= fa_co_s;
          a_sr_q  <= a_sr_q >> 1'b1;
          b_sr_q  <= b_sr_q >> 1'b1;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= fa_co_s;
            state_q <= S_DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // ack wins over a simultaneous start; the master must reissue start
          if (ack) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

  serial_add_ctrl_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .ready (ready_q),
    .busy  (busy_q),
    .done  (done_q),
    .ack   (ack),
    .sum   (sum_q),
    .cout  (cout_q)
  );

endmodule

// fulladd: single-bit full adder cell shared by the serial datapath.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// serial_add_ctrl_chk: handshake properties of the sequencer.
module serial_add_ctrl_chk #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready,
  input  logic             busy,
  input  logic             done,
  input  logic             ack,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout
);

  // Exactly one status flag is high at all times.
  a_onehot_status: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot({ready, busy, done})
  );

  // An unacknowledged result stays valid and unchanged.
  a_hold_until_ack: assert property (
    @(posedge clk) disable iff (!rst_n)
      (done && !ack) |=> (done && $stable(sum) && $stable(cout))
  );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the bit-serial adder,
// using one WIDTH=8 and one WIDTH=1 instance on a shared clock and reset.

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start8, ack8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, ack1, cin1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .ack(ack8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .ack(ack1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // one-hot status invariant on both instances, away from the active edge
  always @(negedge clk) begin
    total++;
    if ($countones({ready8, busy8, done8}) != 1 || $countones({ready1, busy1, done1}) != 1) begin
      bad++;
      $display("FAIL onehot: w8 rbd=%b%b%b w1 rbd=%b%b%b need exactly one", ready8, busy8, done8,
               ready1, busy1, done1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation and wait (bounded) for done; returns edges after the start edge.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      output int lat, output logic [8:0] res);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    step();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    res = {cout8, sum8};
  endtask

  task automatic run1(input logic av, input logic bv, input logic cv,
                      output int lat, output logic [1:0] res);
    start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
    step();
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    lat = 0;
    while (done1 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    res = {cout1, sum1};
  endtask

  task automatic ack8_pulse();
    ack8 = 1'b1;
    step();
    ack8 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if ({ready8, busy8, done8, sum8, cout8} !== {3'b100, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_w8: got rbd=%b%b%b sum=%h cout=%b need 100/00/0", ready8, busy8, done8, sum8, cout8);
    end
    rst_n = 1'b1;
    step();
    step();
    total++;
    if ({ready1, busy1, done1, sum1, cout1} !== {3'b100, 1'b0, 1'b0} || ready8 !== 1'b1 || sum8 !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle: w1 rbd=%b%b%b sum=%b cout=%b w8 ready=%b sum=%h need idle zeros",
               ready1, busy1, done1, sum1, cout1, ready8, sum8);
    end
  endtask

  task automatic test_directed();
    logic [7:0] av [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] bv [4] = '{8'h3C, 8'h01, 8'hFF, 8'h00};
    logic       cv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] ev [4] = '{9'h096, 9'h100, 9'h1FF, 9'h000};
    int lat;
    logic [8:0] res;
    for (int i = 0; i < 4; i++) begin
      run8(av[i], bv[i], cv[i], lat, res);
      total++;
      if (lat != 8) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges need 8", i, lat);
      end
      total++;
      if (res !== ev[i]) begin
        bad++;
        $display("FAIL directed_sum[%0d]: got {cout,sum}=%h need %h", i, res, ev[i]);
      end
      ack8_pulse();
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [8:0] res;
    logic [8:0] held;
    run8(8'hC3, 8'h5E, 1'b1, lat, res);
    held = res;
    total++;
    if (res !== 9'h122) begin
      bad++;
      $display("FAIL hold_result: got %h need 122", res);
    end
    repeat (20) begin
      step();
      total++;
      if (done8 !== 1'b1 || {cout8, sum8} !== held) begin
        bad++;
        $display("FAIL hold_stable: done=%b {cout,sum}=%h need 1/%h", done8, {cout8, sum8}, held);
      end
    end
    ack8_pulse();
    total++;
    if (ready8 !== 1'b1 || {cout8, sum8} !== held) begin
      bad++;
      $display("FAIL hold_after_ack: ready=%b {cout,sum}=%h need 1/%h", ready8, {cout8, sum8}, held);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    step();
    start8 = 1'b0;
    lat = 0;
    step(); lat++;
    step(); lat++;
    start8 = 1'b1; a8 = 8'h70; b8 = 8'h70; ack8 = 1'b1;
    step(); lat++;
    start8 = 1'b0; ack8 = 1'b0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    total++;
    if (lat != 8 || sum8 !== 8'h33 || cout8 !== 1'b0) begin
      bad++;
      $display("FAIL start_busy: lat=%0d sum=%h cout=%b need 8/33/0", lat, sum8, cout8);
    end
    ack8_pulse();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [8:0] res;
    run8(8'h80, 8'h80, 1'b0, lat, res);
    ack8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    step();
    ack8 = 1'b0; start8 = 1'b0;
    total++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || {cout8, sum8} !== 9'h100) begin
      bad++;
      $display("FAIL ack_start_same: ready=%b busy=%b {cout,sum}=%h need 1/0/100", ready8, busy8, {cout8, sum8});
    end
    step();
    total++;
    if (ready8 !== 1'b1) begin
      bad++;
      $display("FAIL start_not_queued: ready=%b need 1", ready8);
    end
    run8(8'h7F, 8'h01, 1'b1, lat, res);
    total++;
    if (lat != 8 || res !== 9'h081) begin
      bad++;
      $display("FAIL back_to_back: lat=%0d res=%h need 8/081", lat, res);
    end
    ack8_pulse();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [8:0] res;
    start8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready8, busy8, done8, sum8, cout8} !== {3'b100, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_midop: rbd=%b%b%b sum=%h cout=%b need 100/00/0", ready8, busy8, done8, sum8, cout8);
    end
    step();
    rst_n = 1'b1;
    step();
    run8(8'h01, 8'h02, 1'b0, lat, res);
    total++;
    if (lat != 8 || res !== 9'h003) begin
      bad++;
      $display("FAIL after_reset_op: lat=%0d res=%h need 8/003", lat, res);
    end
    ack8_pulse();
  endtask

  task automatic test_random_w8();
    int lat;
    logic [8:0] res;
    logic [7:0] av, bv;
    logic cv;
    int exp_v, dly;
    for (int i = 0; i < 500; i++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
      exp_v = int'(av) + int'(bv) + int'(cv);
      run8(av, bv, cv, lat, res);
      total++;
      if (lat != 8 || res !== 9'(exp_v)) begin
        bad++;
        $display("FAIL rand8[%0d]: %h+%h+%b lat=%0d res=%h need 8/%h", i, av, bv, cv, lat, res, 9'(exp_v));
      end
      dly = $urandom_range(5, 0);
      repeat (dly) step();
      total++;
      if (done8 !== 1'b1 || {cout8, sum8} !== 9'(exp_v)) begin
        bad++;
        $display("FAIL rand8_hold[%0d]: done=%b res=%h need 1/%h", i, done8, {cout8, sum8}, 9'(exp_v));
      end
      ack8_pulse();
    end
  endtask

  task automatic test_random_w1();
    int lat;
    logic [1:0] res;
    logic av, bv, cv;
    int exp_v, dly;
    for (int i = 0; i < 120; i++) begin
      av = 1'($urandom); bv = 1'($urandom); cv = 1'($urandom);
      exp_v = int'(av) + int'(bv) + int'(cv);
      run1(av, bv, cv, lat, res);
      total++;
      if (lat != 1 || res !== 2'(exp_v)) begin
        bad++;
        $display("FAIL rand1[%0d]: %b+%b+%b lat=%0d res=%b need 1/%b", i, av, bv, cv, lat, res, 2'(exp_v));
      end
      dly = $urandom_range(5, 0);
      repeat (dly) step();
      ack1 = 1'b1;
      step();
      ack1 = 1'b0;
      total++;
      if (ready1 !== 1'b1 || {cout1, sum1} !== 2'(exp_v)) begin
        bad++;
        $display("FAIL rand1_ack[%0d]: ready=%b res=%b need 1/%b", i, ready1, {cout1, sum1}, 2'(exp_v));
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    start8 = 1'b0; ack8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start1 = 1'b0; ack1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midop();
    test_random_w8();
    test_random_w1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
